if_fetch_unit: RTL and testbench



---
 rtl/lc3b_types.sv | 29 ++
 rtl/fetch_pc_reg.sv | 43 ++++
 rtl/if_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types, fetch FSM encoding and small helpers used by the fetch stage.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_REQ,
      FETCH_HOLD
   } lc3b_fetch_state_t;

   typedef enum logic [1:0] {
      PC_SEL_INC,
      PC_SEL_TARGET,
      PC_SEL_SAVED
   } lc3b_pc_sel_t;

   localparam int unsigned LC3B_INSTR_BYTES = 2;

   // Instructions are halfword aligned, so the low address bit is always cleared.
   function automatic lc3b_word align_word(input lc3b_word addr);
      return addr & 16'hFFFE;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] val);
      return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter for the fetch stage: PC register, +2 incrementer and next-PC select.
module fetch_pc_reg
   import lc3b_types::*;
#(
   parameter lc3b_word RESET_PC = 16'h0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         pc_load,
   input  lc3b_pc_sel_t pc_sel,
   input  lc3b_word     redirect_target,
   input  lc3b_word     redirect_pc,
   output lc3b_word     pc,
   output lc3b_word     pc_plus2
);

   lc3b_word pc_q;
   lc3b_word pc_d;

   assign pc       = pc_q;
   assign pc_plus2 = pc_q + 16'(LC3B_INSTR_BYTES);

   always_comb begin
      pc_d = pc_q;
      if (pc_load) begin
         case (pc_sel)
            PC_SEL_INC:    pc_d = pc_plus2;
            PC_SEL_TARGET: pc_d = align_word(redirect_target);
            PC_SEL_SAVED:  pc_d = redirect_pc;
            default:       pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// LC-3b instruction fetch stage: PC, imem read handshake, one-entry stall buffer, redirects.
// Optional IFETCH_PERF_CNT_EN adds fetch_count / stall_cycles saturating counters.
module if_fetch_unit
   import lc3b_types::*;
#(
   parameter lc3b_word RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  lc3b_word    redirect_target,
   input  logic        imem_resp,
   input  lc3b_word    imem_rdata,
   output logic        imem_read,
   output lc3b_word    imem_address,
   output logic        ifid_load,
   output lc3b_word    pc_out,
`ifdef IFETCH_PERF_CNT_EN
   output logic [31:0] fetch_count,
   output logic [31:0] stall_cycles,
`endif
   output lc3b_word    instruction_out
);

   lc3b_fetch_state_t state_q, state_d;
   logic              squash_q, squash_d;
   lc3b_word          redirect_pc_q, redirect_pc_d;
   lc3b_word          buffer_q, buffer_d;

   logic              pc_load;
   lc3b_pc_sel_t      pc_sel;
   lc3b_word          pc;
   lc3b_word          pc_plus2;
   logic              deliver_fetch;
   logic              deliver_hold;
   logic              active;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk             (clk),
      .reset           (reset),
      .pc_load         (pc_load),
      .pc_sel          (pc_sel),
      .redirect_target (redirect_target),
      .redirect_pc     (redirect_pc_q),
      .pc              (pc),
      .pc_plus2        (pc_plus2)
   );

   always_comb begin
      state_d       = state_q;
      squash_d      = squash_q;
      redirect_pc_d = redirect_pc_q;
      buffer_d      = buffer_q;
      pc_load       = 1'b0;
      pc_sel        = PC_SEL_INC;
      deliver_fetch = 1'b0;
      deliver_hold  = 1'b0;
      case (state_q)
         FETCH_IDLE: begin
            state_d = FETCH_REQ;
         end
         FETCH_REQ: begin
            if (!imem_resp) begin
               // Address must stay stable while the request is open, so only remember the redirect.
               if (redirect) begin
                  squash_d      = 1'b1;
                  redirect_pc_d = align_word(redirect_target);
               end
            end else if (squash_q || redirect) begin
               pc_load  = 1'b1;
               pc_sel   = redirect ? PC_SEL_TARGET : PC_SEL_SAVED;
               squash_d = 1'b0;
            end else if (!stall) begin
               deliver_fetch = 1'b1;
               pc_load       = 1'b1;
               pc_sel        = PC_SEL_INC;
            end else begin
               buffer_d = imem_rdata;
               state_d  = FETCH_HOLD;
            end
         end
         FETCH_HOLD: begin
            if (redirect) begin
               pc_load = 1'b1;
               pc_sel  = PC_SEL_TARGET;
               state_d = FETCH_REQ;
            end else if (!stall) begin
               deliver_hold = 1'b1;
               pc_load      = 1'b1;
               pc_sel       = PC_SEL_INC;
               state_d      = FETCH_REQ;
            end
         end
         default: begin
            state_d = FETCH_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= FETCH_IDLE;
         squash_q      <= 1'b0;
         redirect_pc_q <= '0;
         buffer_q      <= '0;
      end else begin
         state_q       <= state_d;
         squash_q      <= squash_d;
         redirect_pc_q <= redirect_pc_d;
         buffer_q      <= buffer_d;
      end
   end

   // Outputs are forced to zero in IDLE (and therefore immediately on reset).
   always_comb begin
      active          = (state_q != FETCH_IDLE);
      imem_read       = (state_q == FETCH_REQ);
      imem_address    = active ? pc : '0;
      ifid_load       = deliver_fetch | deliver_hold;
      pc_out          = active ? pc_plus2 : '0;
      instruction_out = '0;
      if (active) begin
         instruction_out = deliver_fetch ? imem_rdata : buffer_q;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      fetch_count_d  = fetch_count_q;
      stall_cycles_d = stall_cycles_q;
      if (ifid_load) begin
         fetch_count_d = sat_inc32(fetch_count_q);
      end
      if ((state_q == FETCH_HOLD) || ((state_q == FETCH_REQ) && !imem_resp)) begin
         stall_cycles_d = sat_inc32(stall_cycles_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count_q  <= '0;
         stall_cycles_q <= '0;
      end else begin
         fetch_count_q  <= fetch_count_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign fetch_count  = fetch_count_q;
   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: inputs driven on the falling edge, outputs sampled 1ns later.
module tb_if_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_target;
   logic        imem_resp;
   logic [15:0] imem_rdata;
   logic        imem_read;
   logic [15:0] imem_address;
   logic        ifid_load;
   logic [15:0] pc_out;
   logic [15:0] instruction_out;

   int checks;
   int errors;

   if_fetch_unit #(
      .RESET_PC (16'h0000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_resp       (imem_resp),
      .imem_rdata      (imem_rdata),
      .imem_read       (imem_read),
      .imem_address    (imem_address),
      .ifid_load       (ifid_load),
      .pc_out          (pc_out),
      .instruction_out (instruction_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs after the falling edge, then settle.
   task automatic cyc(input logic resp, input logic [15:0] rdata, input logic stl,
                      input logic redir, input logic [15:0] tgt);
      @(negedge clk);
      imem_resp       = resp;
      imem_rdata      = rdata;
      stall           = stl;
      redirect        = redir;
      redirect_target = tgt;
      #1;
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      reset           = 1'b1;
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_target = 16'h0000;
      imem_resp       = 1'b0;
      imem_rdata      = 16'h0000;

      #2;
      chk("rst_read", {15'd0, imem_read}, 16'h0);
      chk("rst_addr", imem_address, 16'h0000);
      chk("rst_load", {15'd0, ifid_load}, 16'h0);
      chk("rst_pcout", pc_out, 16'h0000);
      chk("rst_instr", instruction_out, 16'h0000);

      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("idle_read", {15'd0, imem_read}, 16'h0);
      chk("idle_load", {15'd0, ifid_load}, 16'h0);

      // Zero-wait memory, back-to-back delivery
      cyc(1'b1, 16'hA000, 1'b0, 1'b0, 16'h0);
      chk("t1_read0", {15'd0, imem_read}, 16'h1);
      chk("t1_addr0", imem_address, 16'h0000);
      chk("t1_load0", {15'd0, ifid_load}, 16'h1);
      chk("t1_pcout0", pc_out, 16'h0002);
      chk("t1_instr0", instruction_out, 16'hA000);
      cyc(1'b1, 16'hA002, 1'b0, 1'b0, 16'h0);
      chk("t1_addr1", imem_address, 16'h0002);
      chk("t1_load1", {15'd0, ifid_load}, 16'h1);
      chk("t1_pcout1", pc_out, 16'h0004);
      chk("t1_instr1", instruction_out, 16'hA002);
      cyc(1'b1, 16'hA004, 1'b0, 1'b0, 16'h0);
      chk("t1_addr2", imem_address, 16'h0004);
      chk("t1_load2", {15'd0, ifid_load}, 16'h1);
      chk("t1_pcout2", pc_out, 16'h0006);

      // Response under stall goes to HOLD
      cyc(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0);
      chk("t2_addr", imem_address, 16'h0006);
      chk("t2_load_stall", {15'd0, ifid_load}, 16'h0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
         chk("t2_hold_read", {15'd0, imem_read}, 16'h0);
         chk("t2_hold_load", {15'd0, ifid_load}, 16'h0);
         chk("t2_hold_instr", instruction_out, 16'h1234);
      end
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      chk("t2_rel_load", {15'd0, ifid_load}, 16'h1);
      chk("t2_rel_instr", instruction_out, 16'h1234);
      chk("t2_rel_pcout", pc_out, 16'h0008);
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0010);
      chk("t2_next_read", {15'd0, imem_read}, 16'h1);
      chk("t2_next_addr", imem_address, 16'h0008);
      chk("t2_next_load", {15'd0, ifid_load}, 16'h0);
      cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0);
      chk("t3_sq_load", {15'd0, ifid_load}, 16'h0);

      // Redirect while the 0010 request is outstanding
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0041);
      chk("t3_addr_a", imem_address, 16'h0010);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      chk("t3_addr_b", imem_address, 16'h0010);
      chk("t3_read_b", {15'd0, imem_read}, 16'h1);
      cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0);
      chk("t3_discard_load", {15'd0, ifid_load}, 16'h0);

      // Redirect in the same cycle as the response
      cyc(1'b1, 16'h5555, 1'b0, 1'b1, 16'h0100);
      chk("t3_new_addr", imem_address, 16'h0040);
      chk("t4_load", {15'd0, ifid_load}, 16'h0);

      // Redirect while holding a buffered instruction
      cyc(1'b1, 16'h6666, 1'b1, 1'b0, 16'h0);
      chk("t4_new_addr", imem_address, 16'h0100);
      cyc(1'b0, 16'h0, 1'b1, 1'b1, 16'h0200);
      chk("t5_hold_read", {15'd0, imem_read}, 16'h0);
      chk("t5_hold_instr", instruction_out, 16'h6666);
      chk("t5_load", {15'd0, ifid_load}, 16'h0);

      // PC wrap at FFFE
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFE);
      chk("t5_new_addr", imem_address, 16'h0200);
      chk("t5_new_read", {15'd0, imem_read}, 16'h1);
      cyc(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0);
      chk("t6_sq_load", {15'd0, ifid_load}, 16'h0);
      cyc(1'b1, 16'h4321, 1'b0, 1'b0, 16'h0);
      chk("t6_addr", imem_address, 16'hFFFE);
      chk("t6_load", {15'd0, ifid_load}, 16'h1);
      chk("t6_pcout", pc_out, 16'h0000);
      chk("t6_instr", instruction_out, 16'h4321);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      chk("t6_wrap_addr", imem_address, 16'h0000);
      chk("t6_wrap_read", {15'd0, imem_read}, 16'h1);

      // Reset in the middle of a request, away from any clock edge
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0300);
      chk("t6_pre_addr", imem_address, 16'h0000);
      #1;
      reset = 1'b1;
      #1;
      chk("t6_mid_read", {15'd0, imem_read}, 16'h0);
      chk("t6_mid_addr", imem_address, 16'h0000);
      chk("t6_mid_load", {15'd0, ifid_load}, 16'h0);
      @(negedge clk);
      reset     = 1'b0;
      redirect  = 1'b0;
      imem_resp = 1'b1;
      #1;
      chk("t6_late_resp_load", {15'd0, ifid_load}, 16'h0);
      chk("t6_late_resp_read", {15'd0, imem_read}, 16'h0);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      chk("t6_restart_read", {15'd0, imem_read}, 16'h1);
      chk("t6_restart_addr", imem_address, 16'h0000);
      chk("t6_restart_load", {15'd0, ifid_load}, 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
